pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed-field ID/EX pipeline register.
- Carries a generic control bundle and data bundle between two pipeline stages using a valid/ready handshake.
- Provides synchronous flush and an optional 2-entry skid buffer, so back-pressure needs no combinational ready path.
- Instantiated between every stage pair (IF/ID, ID/EX, EX/MEM, MEM/WB) in the next-generation pipeline.

Parameters:
- CTRL_W, 8: width of control bundle; control bits are zeroed on bubble, flush and reset.
- DATA_W, 111: width of data bundle (operands, register specifiers, immediate).
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CLR_DATA, 0: 1 = flush also zeroes stored data; 0 = flush zeroes control/valid only, data holds.

Ports:
- CLK  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- CLR  in  1  synchronous flush (hazard unit)
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat this cycle
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- out_valid  out  1  downstream beat present
- out_ready  in  1  downstream accepts this cycle
- out_ctrl  out  CTRL_W  control bundle; forced 0 when out_valid=0
- out_data  out  DATA_W  data bundle from head entry
- count  out  2  occupancy 0..2 (0..1 when SKID=0)

Behaviour:
- Accept = in_valid & in_ready; Send = out_valid & out_ready.
- Priority per edge: rst_n=0 > CLR=1 > transfers.
- Reset (rst_n=0 at edge): all entries, data and control zeroed; count=0, out_valid=0, out_ctrl=0, out_data=0; in_ready=1 on the following cycle. Reset mid-transfer discards both the in-flight and the stored beats.
- Flush (CLR=1, rst_n=1): state -> EMPTY; all control zeroed; data zeroed only if CLR_DATA=1. A beat offered in the CLR cycle is dropped even if in_ready=1. A Send in the CLR cycle completes (downstream saw it); stage still ends EMPTY.
- SKID=1 state machine (main reg M, skid reg S):
  - EMPTY (count 0): Accept -> ONE, M<=in.
  - ONE (count 1): Accept & Send -> ONE, M<=in; Accept & !Send -> FULL, S<=in; !Accept & Send -> EMPTY; otherwise hold.
  - FULL (count 2): in_ready=0; Send -> ONE, M<=S; otherwise hold.
  - in_ready = (state != FULL), driven from a flop with no combinational dependence on out_ready.
  - out_valid = (state != EMPTY); out_data/out_ctrl come from M.
  - Order is preserved: S always holds the younger beat.
- SKID=0: single entry; in_ready = !out_valid | out_ready (combinational); Accept overwrites M in the same edge as Send; count is 0 or 1.
- Latency: an accepted beat appears on out_* the next cycle when the stage is EMPTY, or in the ONE state with Send.
- Throughput: one beat per cycle sustained when out_ready=1.
- Hold: with no Send, out_ctrl/out_data are stable; data is never overwritten while valid and unsent.
- out_ctrl is gated by out_valid, so a bubble presents all-zero control (NOP: no RegWrite/MemWrite).

Test Plan:
- Reset then stream: rst_n=0 for 2 cycles, then in_valid=1 with data 1,2,3 and out_ready=1 -> out_valid rises 1 cycle after the first accept; out_data=1,2,3 on consecutive cycles; count=1 throughout.
- Back-pressure (SKID=1): send 0xA, 0xB, 0xC, then out_ready=0 -> 0xA held at output, 0xB in skid, count=2, in_ready=0, 0xC held upstream. Release out_ready -> outputs 0xA, 0xB, 0xC in order with no loss or duplication.
- Flush while FULL: count=2, assert CLR for 1 cycle -> next cycle out_valid=0, out_ctrl=0, count=0, in_ready=1. With CLR_DATA=0, out_data retains the old value; with CLR_DATA=1, out_data=0.
- CLR with simultaneous accept: in_valid=1, in_ready=1, CLR=1 -> beat dropped, count=0 next cycle.
- Reset mid-operation: count=2 and rst_n=0 together with CLR=0 and in_valid=1 -> all outputs zero next cycle, count=0.
- SKID=0 pass-through: out_ready toggles 1,0,1 with in_valid=1 -> in_ready mirrors out_ready while full; no beat lost; count never exceeds 1.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register between two stages with a valid/ready handshake.
// SKID=1 builds a 2-entry skid buffer (main reg M, skid reg S) whose in_ready
// comes straight from a flop; SKID=0 builds a single register whose in_ready
// looks through to out_ready. Control bits are forced to zero whenever the
// stage presents a bubble, so a bubble always reads as a NOP downstream.
module pipe_stage_elastic #(
  parameter int CTRL_W   = 8,
  parameter int DATA_W   = 111,
  parameter int SKID     = 1,
  parameter int CLR_DATA = 0
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              CLR,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic              accept;
  logic              send;
  logic [CTRL_W-1:0] mCtrl;
  logic [DATA_W-1:0] mData;

  assign accept   = in_valid & in_ready;
  assign send     = out_valid & out_ready;
  // Gate control with valid so a bubble never carries stale RegWrite/MemWrite.
  assign out_ctrl = out_valid ? mCtrl : '0;
  assign out_data = mData;

  if (SKID != 0) begin : gSkid
    logic [1:0]        state;
    logic [1:0]        nextState;
    logic              inReadyQ;
    logic [CTRL_W-1:0] sCtrl;
    logic [DATA_W-1:0] sData;
    logic              loadMFromIn;
    logic              loadMFromS;
    logic              loadS;

    // Which register captures what on this edge (transfer path only).
    assign loadMFromIn = accept & ((state == EMPTY) | ((state == ONE) & send));
    assign loadS       = accept & (state == ONE) & ~send;
    assign loadMFromS  = send & (state == FULL);

    // Next occupancy from the handshake outcome of this cycle.
    always_comb begin
      // NOTE: default first so every path assigns nextState and no latch is inferred.
      nextState = state;
      case (state)
        EMPTY:   if (accept) nextState = ONE;
        ONE: begin
          if (accept && !send)      nextState = FULL;
          else if (!accept && send) nextState = EMPTY;
        end
        FULL:    if (send) nextState = ONE;
        default: nextState = EMPTY;
      endcase
    end

    // Occupancy, registered ready and control bundles; reset beats flush.
    always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      if (!rst_n) begin
        state    <= EMPTY;
        inReadyQ <= 1'b1;
        mCtrl    <= '0;
        sCtrl    <= '0;
      end else if (CLR) begin
        state    <= EMPTY;
        inReadyQ <= 1'b1;
        mCtrl    <= '0;
        sCtrl    <= '0;
      end else begin
        state    <= nextState;
        inReadyQ <= (nextState != FULL);
        if (loadMFromIn)     mCtrl <= in_ctrl;
        else if (loadMFromS) mCtrl <= sCtrl;
        if (loadS)           sCtrl <= in_ctrl;
      end
    end

    // Data bundles: cleared on reset, on flush only when CLR_DATA is set.
    always_ff @(posedge CLK) begin
      // NOTE: these wide registers are reset on purpose so out_data reads zero after reset.
      if (!rst_n) begin
        mData <= '0;
        sData <= '0;
      end else if (CLR) begin
        if (CLR_DATA != 0) begin
          mData <= '0;
          sData <= '0;
        end
      end else begin
        if (loadMFromIn)     mData <= in_data;
        else if (loadMFromS) mData <= sData;
        if (loadS)           sData <= in_data;
      end
    end

    assign in_ready  = inReadyQ;
    assign out_valid = (state != EMPTY);
    assign count     = state;
  end else begin : gPass
    logic validQ;

    // Single entry: valid flag and control, refilled in the same edge as a send.
    always_ff @(posedge CLK) begin
      if (!rst_n) begin
        validQ <= 1'b0;
        mCtrl  <= '0;
      end else if (CLR) begin
        validQ <= 1'b0;
        mCtrl  <= '0;
      end else if (accept) begin
        validQ <= 1'b1;
        mCtrl  <= in_ctrl;
      end else if (send) begin
        validQ <= 1'b0;
      end
    end

    // Single entry data: cleared on reset, on flush only when CLR_DATA is set.
    always_ff @(posedge CLK) begin
      if (!rst_n) begin
        mData <= '0;
      end else if (CLR) begin
        if (CLR_DATA != 0) mData <= '0;
      end else if (accept) begin
        mData <= in_data;
      end
    end

    assign in_ready  = ~validQ | out_ready;
    assign out_valid = validQ;
    assign count     = {1'b0, validQ};
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: two skid instances in lockstep (flush keeps
// data vs. flush clears data) and one pass-through instance. Expected beats
// are queued on accept and compared when each stage sends.
module tb_pipe_stage_elastic;

  localparam int CW = 8;
  localparam int DW = 111;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } beat_t;

  logic CLK = 1'b0;
  logic rst_n;
  logic CLR;

  // Shared stimulus for the two skid instances.
  logic          sInValid;
  logic [CW-1:0] sInCtrl;
  logic [DW-1:0] sInData;
  logic          sOutReady;
  logic          sInReady,  cInReady;
  logic          sOutValid, cOutValid;
  logic [CW-1:0] sOutCtrl,  cOutCtrl;
  logic [DW-1:0] sOutData,  cOutData;
  logic [1:0]    sCount,    cCount;

  // Pass-through instance.
  logic          pInValid;
  logic [CW-1:0] pInCtrl;
  logic [DW-1:0] pInData;
  logic          pOutReady;
  logic          pInReady;
  logic          pOutValid;
  logic [CW-1:0] pOutCtrl;
  logic [DW-1:0] pOutData;
  logic [1:0]    pCount;

  int errors = 0;
  int checks = 0;

  beat_t sq[$];
  beat_t pq[$];

  always #5 CLK = ~CLK;

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLR_DATA(0)) u_skid (
    .CLK(CLK), .rst_n(rst_n), .CLR(CLR),
    .in_valid(sInValid), .in_ready(sInReady), .in_ctrl(sInCtrl), .in_data(sInData),
    .out_valid(sOutValid), .out_ready(sOutReady), .out_ctrl(sOutCtrl), .out_data(sOutData),
    .count(sCount)
  );

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLR_DATA(1)) u_clr (
    .CLK(CLK), .rst_n(rst_n), .CLR(CLR),
    .in_valid(sInValid), .in_ready(cInReady), .in_ctrl(sInCtrl), .in_data(sInData),
    .out_valid(cOutValid), .out_ready(sOutReady), .out_ctrl(cOutCtrl), .out_data(cOutData),
    .count(cCount)
  );

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CLR_DATA(0)) u_pass (
    .CLK(CLK), .rst_n(rst_n), .CLR(CLR),
    .in_valid(pInValid), .in_ready(pInReady), .in_ctrl(pInCtrl), .in_data(pInData),
    .out_valid(pOutValid), .out_ready(pOutReady), .out_ctrl(pOutCtrl), .out_data(pOutData),
    .count(pCount)
  );

  function automatic logic [CW-1:0] mkCtrl(input int v);
    logic [31:0] t;
    t = v;
    return {1'b1, t[CW-2:0]};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sDrive(input logic valid, input int v);
    sInValid = valid;
    sInData  = DW'(v);
    sInCtrl  = mkCtrl(v);
  endtask

  // Scoreboard for the skid instance: pop on send, then drop or push on accept.
  always @(negedge CLK) begin
    if (!rst_n) begin
      sq.delete();
    end else begin
      if (sOutValid && sOutReady) begin
        checks++;
        if (sq.size() == 0) begin
          errors++;
          $display("FAIL skid_sb_extra: sent data=%0h with nothing outstanding", sOutData);
        end else begin
          beat_t e;
          e = sq.pop_front();
          if (sOutData !== e.data || sOutCtrl !== e.ctrl) begin
            errors++;
            $display("FAIL skid_sb_beat: got ctrl=%0h data=%0h expected ctrl=%0h data=%0h",
                     sOutCtrl, sOutData, e.ctrl, e.data);
          end
        end
      end
      if (CLR) sq.delete();
      else if (sInValid && sInReady) sq.push_back('{ctrl: sInCtrl, data: sInData});
    end
  end

  // Scoreboard for the pass-through instance.
  always @(negedge CLK) begin
    if (!rst_n) begin
      pq.delete();
    end else begin
      if (pOutValid && pOutReady) begin
        checks++;
        if (pq.size() == 0) begin
          errors++;
          $display("FAIL pass_sb_extra: sent data=%0h with nothing outstanding", pOutData);
        end else begin
          beat_t e;
          e = pq.pop_front();
          if (pOutData !== e.data || pOutCtrl !== e.ctrl) begin
            errors++;
            $display("FAIL pass_sb_beat: got ctrl=%0h data=%0h expected ctrl=%0h data=%0h",
                     pOutCtrl, pOutData, e.ctrl, e.data);
          end
        end
      end
      if (CLR) pq.delete();
      else if (pInValid && pInReady) pq.push_back('{ctrl: pInCtrl, data: pInData});
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (sOutValid !== 1'b0 || sOutCtrl !== '0 || sOutData !== '0) begin
      errors++;
      $display("FAIL reset_out: got valid=%b ctrl=%0h data=%0h expected 0 0 0",
               sOutValid, sOutCtrl, sOutData);
    end
    checks++;
    if (sCount !== 2'd0 || sInReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got count=%0d in_ready=%b expected 0 1", sCount, sInReady);
    end
    checks++;
    if (pCount !== 2'd0 || pOutValid !== 1'b0 || pInReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_pass: got count=%0d valid=%b in_ready=%b expected 0 0 1",
               pCount, pOutValid, pInReady);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    sOutReady = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      sDrive(1'b1, v);
      tick();
      checks++;
      if (sOutValid !== 1'b1 || sOutData !== DW'(v) || sCount !== 2'd1) begin
        errors++;
        $display("FAIL stream_%0d: got valid=%b data=%0h count=%0d expected 1 %0h 1",
                 v, sOutValid, sOutData, sCount, v);
      end
    end
    sDrive(1'b0, 0);
    tick();
    checks++;
    if (sOutValid !== 1'b0 || sOutCtrl !== '0 || sCount !== 2'd0) begin
      errors++;
      $display("FAIL stream_drain: got valid=%b ctrl=%0h count=%0d expected 0 0 0",
               sOutValid, sOutCtrl, sCount);
    end
  endtask

  task automatic test_backpressure();
    sOutReady = 1'b0;
    sDrive(1'b1, 'hA);
    tick();
    sDrive(1'b1, 'hB);
    tick();
    sDrive(1'b1, 'hC);
    tick();
    checks++;
    if (sOutData !== DW'('hA) || sCount !== 2'd2 || sInReady !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: got data=%0h count=%0d in_ready=%b expected a 2 0",
               sOutData, sCount, sInReady);
    end
    tick();
    checks++;
    if (sOutData !== DW'('hA) || sOutCtrl !== mkCtrl('hA) || sCount !== 2'd2) begin
      errors++;
      $display("FAIL bp_hold: got ctrl=%0h data=%0h count=%0d expected %0h a 2",
               sOutCtrl, sOutData, sCount, mkCtrl('hA));
    end
    sOutReady = 1'b1;
    tick();
    checks++;
    if (sOutData !== DW'('hB) || sCount !== 2'd1 || sInReady !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got data=%0h count=%0d in_ready=%b expected b 1 1",
               sOutData, sCount, sInReady);
    end
    tick();
    checks++;
    if (sOutData !== DW'('hC) || sCount !== 2'd1) begin
      errors++;
      $display("FAIL bp_third: got data=%0h count=%0d expected c 1", sOutData, sCount);
    end
    sDrive(1'b0, 0);
    tick();
    checks++;
    if (sCount !== 2'd0 || sq.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: got count=%0d outstanding=%0d expected 0 0", sCount, sq.size());
    end
  endtask

  task automatic test_flush_full();
    sOutReady = 1'b0;
    sDrive(1'b1, 'hD);
    tick();
    sDrive(1'b1, 'hE);
    tick();
    sDrive(1'b0, 0);
    checks++;
    if (sCount !== 2'd2 || cCount !== 2'd2) begin
      errors++;
      $display("FAIL flush_fill: got count=%0d/%0d expected 2/2", sCount, cCount);
    end
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    checks++;
    if (sOutValid !== 1'b0 || sOutCtrl !== '0 || sCount !== 2'd0 || sInReady !== 1'b1) begin
      errors++;
      $display("FAIL flush_state: got valid=%b ctrl=%0h count=%0d in_ready=%b expected 0 0 0 1",
               sOutValid, sOutCtrl, sCount, sInReady);
    end
    checks++;
    if (sOutData !== DW'('hD)) begin
      errors++;
      $display("FAIL flush_keep_data: got data=%0h expected d", sOutData);
    end
    checks++;
    if (cOutData !== '0 || cOutValid !== 1'b0 || cOutCtrl !== '0 || cCount !== 2'd0) begin
      errors++;
      $display("FAIL flush_clr_data: got data=%0h valid=%b ctrl=%0h count=%0d expected 0 0 0 0",
               cOutData, cOutValid, cOutCtrl, cCount);
    end
  endtask

  task automatic test_clr_accept();
    // Empty stage, beat offered during CLR: dropped.
    sOutReady = 1'b1;
    sDrive(1'b1, 'h55);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    sDrive(1'b0, 0);
    checks++;
    if (sCount !== 2'd0 || sOutValid !== 1'b0) begin
      errors++;
      $display("FAIL clr_drop: got count=%0d valid=%b expected 0 0", sCount, sOutValid);
    end
    // One beat held; CLR with a send and a new offer: send completes, new beat dropped.
    sDrive(1'b1, 'hF);
    tick();
    sDrive(1'b1, 'h66);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    sDrive(1'b0, 0);
    checks++;
    if (sCount !== 2'd0 || sOutValid !== 1'b0 || sq.size() != 0) begin
      errors++;
      $display("FAIL clr_send: got count=%0d valid=%b outstanding=%0d expected 0 0 0",
               sCount, sOutValid, sq.size());
    end
  endtask

  task automatic test_reset_mid();
    sOutReady = 1'b0;
    sDrive(1'b1, 'h11);
    tick();
    sDrive(1'b1, 'h12);
    tick();
    sDrive(1'b1, 'h13);
    CLR   = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++;
    if (sOutValid !== 1'b0 || sOutCtrl !== '0 || sOutData !== '0 ||
        sCount !== 2'd0 || sInReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b ctrl=%0h data=%0h count=%0d in_ready=%b expected 0 0 0 0 1",
               sOutValid, sOutCtrl, sOutData, sCount, sInReady);
    end
    rst_n = 1'b1;
    sDrive(1'b0, 0);
    tick();
  endtask

  task automatic test_pass_through();
    int  v;
    bit  acc;
    v = 1;
    for (int i = 0; i < 8; i++) begin
      pInValid  = 1'b1;
      pInData   = DW'(v);
      pInCtrl   = mkCtrl(v);
      pOutReady = (i % 2 == 0);
      #1;
      checks++;
      if (pInReady !== (!pOutValid || pOutReady)) begin
        errors++;
        $display("FAIL pass_ready_%0d: got in_ready=%b expected %b",
                 i, pInReady, (!pOutValid || pOutReady));
      end
      acc = pInReady;
      tick();
      checks++;
      if (pCount > 2'd1 || pOutValid !== 1'b1) begin
        errors++;
        $display("FAIL pass_count_%0d: got count=%0d valid=%b expected <=1 1", i, pCount, pOutValid);
      end
      if (acc) v++;
    end
    pInValid  = 1'b0;
    pOutReady = 1'b1;
    tick();
    tick();
    checks++;
    if (pCount !== 2'd0 || pq.size() != 0 || pOutCtrl !== '0) begin
      errors++;
      $display("FAIL pass_drain: got count=%0d outstanding=%0d ctrl=%0h expected 0 0 0",
               pCount, pq.size(), pOutCtrl);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    CLR       = 1'b0;
    sInValid  = 1'b0;
    sInCtrl   = '0;
    sInData   = '0;
    sOutReady = 1'b0;
    pInValid  = 1'b0;
    pInCtrl   = '0;
    pInData   = '0;
    pOutReady = 1'b0;

    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_clr_accept();
    test_reset_mid();
    test_pass_through();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
